// File: rtl/comp_unit.sv
// Registered N-bit magnitude comparator (eq/gt/lt) built on a log-depth merge tree.
// Build option COMP_UNIT_SIGNED_EN adds an is_signed input for two's-complement compares.
module comp_unit #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         valid_in,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
`ifdef COMP_UNIT_SIGNED_EN
  input  logic         is_signed,
`endif
  output logic         a_eq_b,
  output logic         a_gt_b,
  output logic         a_lt_b,
  output logic         valid_out
);

  // Leaf count rounded up to a power of two; padded leaves compare 0 vs 0 (eq=1, gt=0).
  localparam int P = 1 << $clog2(N);

  logic [P-1:0]   w_a_pad;
  logic [P-1:0]   w_b_pad;
  logic [2*P-2:0] w_gt;
  logic [2*P-2:0] w_eq;
  logic           w_lt;

  logic r_valid;
  logic r_eq;
  logic r_gt;
  logic r_lt;

  always_comb begin
    w_a_pad          = '0;
    w_b_pad          = '0;
    w_a_pad[N-1:0]   = a;
    w_b_pad[N-1:0]   = b;
`ifdef COMP_UNIT_SIGNED_EN
    // Flipping both sign bits maps two's complement onto unsigned ordering.
    w_a_pad[N-1]     = a[N-1] ^ is_signed;
    w_b_pad[N-1]     = b[N-1] ^ is_signed;
`endif
  end

  // Heap-ordered tree: node i has low child 2i+1 and high child 2i+2; leaf P-1+j is bit j.
  // NOTE: blocking assignments here are intentional; each node reads children
  // computed earlier in the same pass, and the defaults first prevent latches.
  always_comb begin
    w_gt = '0;
    w_eq = '0;
    for (int j = 0; j < P; j++) begin
      w_gt[P-1+j] = w_a_pad[j] & ~w_b_pad[j];
      w_eq[P-1+j] = ~(w_a_pad[j] ^ w_b_pad[j]);
    end
    for (int i = P - 2; i >= 0; i--) begin
      w_gt[i] = w_gt[2*i+2] | (w_eq[2*i+2] & w_gt[2*i+1]);
      w_eq[i] = w_eq[2*i+2] & w_eq[2*i+1];
    end
  end

  assign w_lt = ~w_gt[0] & ~w_eq[0];

  // NOTE: the flags only load on valid_in, so they hold (and ignore X operands)
  // on idle cycles; reset is synchronous and takes priority over valid_in.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_eq    <= 1'b0;
      r_gt    <= 1'b0;
      r_lt    <= 1'b0;
    end else begin
      r_valid <= valid_in;
      if (valid_in) begin
        r_eq <= w_eq[0];
        r_gt <= w_gt[0];
        r_lt <= w_lt;
      end
    end
  end

  assign valid_out = r_valid;
  assign a_eq_b    = r_eq;
  assign a_gt_b    = r_gt;
  assign a_lt_b    = r_lt;

endmodule

// File: tb/tb_comp_unit.sv
// Self-checking bench for comp_unit: golden flags are queued at drive time and
// popped when valid_out rises; idle cycles check that the flags hold.
module tb_comp_unit;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         valid_in;
  logic [N-1:0] a;
  logic [N-1:0] b;
`ifdef COMP_UNIT_SIGNED_EN
  logic         is_signed;
`endif
  logic         a_eq_b;
  logic         a_gt_b;
  logic         a_lt_b;
  logic         valid_out;

  typedef struct packed {
    logic eq;
    logic gt;
    logic lt;
  } flags_t;

  flags_t sb_q[$];
  flags_t last_exp;
  flags_t got;
  logic   exp_valid = 1'b0;
  logic   exp_rst   = 1'b0;
  logic   mon_en    = 1'b0;
  int     n_checks  = 0;
  int     n_errors  = 0;

  comp_unit #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .a         (a),
    .b         (b),
`ifdef COMP_UNIT_SIGNED_EN
    .is_signed (is_signed),
`endif
    .a_eq_b    (a_eq_b),
    .a_gt_b    (a_gt_b),
    .a_lt_b    (a_lt_b),
    .valid_out (valid_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic flags_t golden(input logic [N-1:0] x, input logic [N-1:0] y, input logic sgn);
    flags_t f;
    if (sgn) begin
      f.eq = (x == y);
      f.gt = ($signed(x) > $signed(y));
      f.lt = ($signed(x) < $signed(y));
    end else begin
      f.eq = (x == y);
      f.gt = (x > y);
      f.lt = (x < y);
    end
    return f;
  endfunction

  // Drive one cycle of stimulus on the falling edge; queue the golden result if it will be captured.
  task automatic drive(input logic r, input logic v, input logic [N-1:0] x,
                       input logic [N-1:0] y, input logic sgn);
    @(negedge clk);
    rst_n    = r;
    valid_in = v;
    a        = x;
    b        = y;
`ifdef COMP_UNIT_SIGNED_EN
    is_signed = sgn;
`endif
    if (r && v) sb_q.push_back(golden(x, y, sgn));
  endtask

  // Bench-side view of what the capture edge should produce.
  always @(posedge clk) begin
    mon_en    <= 1'b1;
    exp_valid <= rst_n && valid_in;
    exp_rst   <= !rst_n;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      got = '{eq: a_eq_b, gt: a_gt_b, lt: a_lt_b};
      if (exp_rst) last_exp = '0;
      check("valid_out", {31'd0, valid_out}, {31'd0, exp_valid});
      if (valid_out) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          last_exp = sb_q.pop_front();
          check("flags", {29'd0, got}, {29'd0, last_exp});
        end
        check("onehot", $countones(got), 32'd1);
      end else begin
        check("hold", {29'd0, got}, {29'd0, last_exp});
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    valid_in = 1'b0;
    a        = '0;
    b        = '0;
`ifdef COMP_UNIT_SIGNED_EN
    is_signed = 1'b0;
`endif
    last_exp = '0;

    // Reset held with valid operands present; nothing may be captured.
    repeat (3) drive(1'b0, 1'b1, 32'd5, 32'd3, 1'b0);
    drive(1'b1, 1'b1, 32'd5, 32'd3, 1'b0);

    // Directed corners.
    drive(1'b1, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
    drive(1'b1, 1'b1, 32'h80000000, 32'h7FFFFFFF, 1'b0);
    drive(1'b1, 1'b1, 32'h7FFFFFFF, 32'h80000000, 1'b0);
    drive(1'b1, 1'b1, 32'h00000001, 32'h00000000, 1'b0);
    drive(1'b1, 1'b1, 32'h00000000, 32'h00000001, 1'b0);
    drive(1'b1, 1'b1, 32'h00000000, 32'h00000000, 1'b0);
    drive(1'b1, 1'b1, 32'hFFFFFFFF, 32'h00000000, 1'b0);
    drive(1'b1, 1'b1, 32'hFFFFFFFE, 32'hFFFFFFFF, 1'b0);
    drive(1'b1, 1'b1, 32'h80000000, 32'h00000000, 1'b0);

    // Back-to-back random stream with periodic equal pairs.
    for (int i = 0; i < 512; i++) begin
      logic [N-1:0] ra;
      logic [N-1:0] rb;
      ra = $urandom;
      rb = (i % 32 == 0) ? ra : $urandom;
      drive(1'b1, 1'b1, ra, rb, 1'b0);
    end

    // Hold: flags must keep a_lt_b while idle, including with X operands.
    drive(1'b1, 1'b1, 32'd2, 32'd9, 1'b0);
    drive(1'b1, 1'b0, $urandom, $urandom, 1'b0);
    drive(1'b1, 1'b0, 'x, 'x, 1'b0);
    drive(1'b1, 1'b0, $urandom, $urandom, 1'b0);
    drive(1'b1, 1'b0, $urandom, $urandom, 1'b0);

    // Reset mid-stream, then the first valid after release.
    drive(1'b1, 1'b1, 32'd100, 32'd7, 1'b0);
    drive(1'b0, 1'b1, 32'd1, 32'd2, 1'b0);
    drive(1'b0, 1'b0, 32'd1, 32'd2, 1'b0);
    drive(1'b1, 1'b1, 32'd3, 32'd3, 1'b0);
    drive(1'b1, 1'b1, 32'd4, 32'd9, 1'b0);

`ifdef COMP_UNIT_SIGNED_EN
    drive(1'b1, 1'b1, 32'hFFFFFFFF, 32'h00000001, 1'b1);
    drive(1'b1, 1'b1, 32'hFFFFFFFF, 32'h00000001, 1'b0);
    drive(1'b1, 1'b1, 32'h80000000, 32'h7FFFFFFF, 1'b1);
    drive(1'b1, 1'b1, 32'h7FFFFFFF, 32'h80000000, 1'b1);
    drive(1'b1, 1'b1, 32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1);
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, 1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)));
    end
`endif

    repeat (4) drive(1'b1, 1'b0, '0, '0, 1'b0);
    check("sb_drain", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
